// File: rtl/mem_access_unit.sv
// Sequencer between the string-search execute stage and the 256-byte data memory.
// Handles load/store/burst-load/set-pointer requests and holds read beats until consumed.
module mem_access_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [1:0] req_sel,
    input  logic [3:0] req_len,
    input  logic       req_use_ptr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic [7:0] ptr,
    output logic [7:0] dataAddress,
    output logic [7:0] data,
    output logic [1:0] sel,
    output logic       memWrite,
    output logic       memRead,
    input  logic [7:0] dataOut
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_STORE  = 2'd1;
    localparam logic [1:0] OP_BURST  = 2'd2;
    localparam logic [1:0] OP_SETPTR = 2'd3;

    state_t     state_q;
    logic [7:0] ptr_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [1:0] rdSel_q;
    logic [3:0] remaining_q;
    logic       usePtr_q;
    logic       rspValid_q;
    logic [7:0] rspData_q;
    logic       rspLast_q;
    logic       memRead_q;
    logic       memWrite_q;
    logic [7:0] memAddr_q;
    logic [7:0] memData_q;
    logic [1:0] memSel_q;

    logic [7:0] reqAddr_d;
    logic [1:0] reqSel_d;
    logic [3:0] remaining_d;

    always_comb begin
        reqAddr_d   = req_use_ptr ? ptr_q : req_addr;
        reqSel_d    = (req_sel == 2'd3) ? 2'd0 : req_sel;
        remaining_d = (req_op == OP_BURST) ? req_len : 4'd0;
    end

    // READ and WRITE entered from IDLE spend one setup cycle before the memory
    // strobe rises; READ re-entered from RESP strobes immediately to keep bursts
    // at one beat every two cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 8'h00;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdSel_q     <= 2'd0;
            remaining_q <= 4'd0;
            usePtr_q    <= 1'b0;
            rspValid_q  <= 1'b0;
            rspData_q   <= 8'h00;
            rspLast_q   <= 1'b0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= 8'h00;
            memData_q   <= 8'h00;
            memSel_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        case (req_op)
                            OP_SETPTR: ptr_q <= req_addr;
                            OP_STORE: begin
                                addr_q  <= reqAddr_d;
                                wdata_q <= req_wdata;
                                state_q <= WRITE;
                            end
                            OP_LOAD, OP_BURST: begin
                                addr_q      <= reqAddr_d;
                                rdSel_q     <= reqSel_d;
                                remaining_q <= remaining_d;
                                usePtr_q    <= req_use_ptr;
                                state_q     <= READ;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
                WRITE: begin
                    if (!memWrite_q) begin
                        memWrite_q <= 1'b1;
                        memAddr_q  <= addr_q;
                        memData_q  <= wdata_q;
                    end else begin
                        memWrite_q <= 1'b0;
                        memAddr_q  <= 8'h00;
                        memData_q  <= 8'h00;
                        state_q    <= IDLE;
                    end
                end
                READ: begin
                    if (!memRead_q) begin
                        memRead_q <= 1'b1;
                        memAddr_q <= addr_q;
                        memSel_q  <= rdSel_q;
                    end else begin
                        rspData_q  <= dataOut;
                        rspValid_q <= 1'b1;
                        rspLast_q  <= (remaining_q == 4'd0);
                        addr_q     <= addr_q + 8'd1;
                        if (usePtr_q) begin
                            ptr_q <= ptr_q + 8'd1;
                        end
                        memRead_q  <= 1'b0;
                        memAddr_q  <= 8'h00;
                        memSel_q   <= 2'd0;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        if (remaining_q == 4'd0) begin
                            rspLast_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            remaining_q <= remaining_q - 4'd1;
                            memRead_q   <= 1'b1;
                            memAddr_q   <= addr_q;
                            memSel_q    <= rdSel_q;
                            state_q     <= READ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rspValid_q;
    assign rsp_data    = rspData_q;
    assign rsp_last    = rspLast_q;
    assign ptr         = ptr_q;
    assign dataAddress = memAddr_q;
    assign data        = memData_q;
    assign sel         = memSel_q;
    assign memWrite    = memWrite_q;
    assign memRead     = memRead_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256-byte memory that
// applies the nibble select and presents read data after the falling edge.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_sel;
    logic [3:0] req_len;
    logic       req_use_ptr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic [7:0] ptr;
    logic [7:0] dataAddress;
    logic [7:0] data;
    logic [1:0] sel;
    logic       memWrite;
    logic       memRead;
    logic [7:0] dataOut;

    logic [7:0] mem [256];
    bit         overlapSeen;
    int         checks = 0;
    int         errors = 0;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .req_len(req_len), .req_use_ptr(req_use_ptr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .ptr(ptr),
        .dataAddress(dataAddress), .data(data), .sel(sel),
        .memWrite(memWrite), .memRead(memRead), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    // Memory contents are reloaded whenever reset is held so every test sees the same image.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h20] <= 8'hA7;
            mem[8'hFE] <= 8'h11;
            mem[8'hFF] <= 8'h22;
            mem[8'h00] <= 8'h33;
            mem[8'h01] <= 8'h44;
            mem[8'h40] <= 8'hB0;
            mem[8'h41] <= 8'hB1;
            mem[8'h42] <= 8'hB2;
            mem[8'h43] <= 8'hB3;
        end else if (memWrite) begin
            mem[dataAddress] <= data;
        end
    end

    always @(negedge clk) begin
        if (memRead) begin
            case (sel)
                2'd1:    dataOut <= {4'h0, mem[dataAddress][3:0]};
                2'd2:    dataOut <= {4'h0, mem[dataAddress][7:4]};
                default: dataOut <= mem[dataAddress];
            endcase
        end else begin
            dataOut <= 8'h00;
        end
        if (memRead && memWrite) overlapSeen <= 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [1:0] s, input logic [3:0] len, input logic usePtr);
        req_op      = op;
        req_addr    = addr;
        req_wdata   = wdata;
        req_sel     = s;
        req_len     = len;
        req_use_ptr = usePtr;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0; req_op = 2'd0; req_addr = 8'h00; req_wdata = 8'h00;
        req_sel = 2'd0; req_len = 4'd0; req_use_ptr = 1'b0; rsp_ready = 1'b0;
        tick; tick; tick;
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got %b want 0", rsp_last); end
        checks++; if (ptr !== 8'h00) begin errors++; $display("FAIL reset_ptr got %h want 00", ptr); end
        checks++; if ({memRead, memWrite, dataAddress, data, sel} !== 20'h0) begin errors++; $display("FAIL reset_mem_pins got rd=%b wr=%b a=%h d=%h s=%0d want all 0", memRead, memWrite, dataAddress, data, sel); end
    endtask

    task automatic test_store_load;
        applyStimulus(2'd1, 8'h10, 8'h5A, 2'd0, 4'd0, 1'b0);
        tick;
        checks++; if (memWrite !== 1'b1 || dataAddress !== 8'h10 || data !== 8'h5A || memRead !== 1'b0) begin errors++; $display("FAIL store_pins got wr=%b rd=%b a=%h d=%h want wr=1 rd=0 a=10 d=5A", memWrite, memRead, dataAddress, data); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL store_busy got req_ready=%b want 0", req_ready); end
        tick;
        checks++; if (memWrite !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL store_done got wr=%b ready=%b want 0 1", memWrite, req_ready); end
        checks++; if (mem[8'h10] !== 8'h5A) begin errors++; $display("FAIL store_mem got %h want 5A", mem[8'h10]); end
        applyStimulus(2'd0, 8'h10, 8'h00, 2'd0, 4'd0, 1'b0);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_early1 got rsp_valid=%b want 0", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b0 || memRead !== 1'b1 || dataAddress !== 8'h10) begin errors++; $display("FAIL load_read got valid=%b rd=%b a=%h want 0 1 10", rsp_valid, memRead, dataAddress); end
        tick;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rsp_last !== 1'b1 || memRead !== 1'b0) begin errors++; $display("FAIL load_rsp got valid=%b data=%h last=%b rd=%b want 1 5A 1 0", rsp_valid, rsp_data, rsp_last, memRead); end
        rsp_ready = 1'b1;
        tick;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL load_done got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_sel;
        logic [7:0] expData [3];
        logic [1:0] expPin [3];
        expData = '{8'h07, 8'h0A, 8'hA7};
        expPin  = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'd0, 8'h20, 8'h00, 2'(i + 1), 4'd0, 1'b0);
            tick;
            checks++; if (sel !== expPin[i]) begin errors++; $display("FAIL sel_pin%0d got %0d want %0d", i + 1, sel, expPin[i]); end
            tick;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== expData[i]) begin errors++; $display("FAIL sel_data%0d got valid=%b data=%h want 1 %h", i + 1, rsp_valid, rsp_data, expData[i]); end
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_ptr_burst;
        logic [7:0] beats [$];
        logic [7:0] addrs [$];
        logic       lasts [$];
        logic [7:0] expBeat [4];
        logic [7:0] expAddr [4];
        bit         done = 1'b0;
        expBeat = '{8'h11, 8'h22, 8'h33, 8'h44};
        expAddr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        applyStimulus(2'd3, 8'hFE, 8'h00, 2'd0, 4'd0, 1'b0);
        checks++; if (ptr !== 8'hFE || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL setptr got ptr=%h ready=%b valid=%b want FE 1 0", ptr, req_ready, rsp_valid); end
        rsp_ready = 1'b1;
        applyStimulus(2'd2, 8'h00, 8'h00, 2'd0, 4'd3, 1'b1);
        for (int c = 0; c < 30 && !done; c++) begin
            tick;
            if (memRead) addrs.push_back(dataAddress);
            if (rsp_valid) begin
                beats.push_back(rsp_data);
                lasts.push_back(rsp_last);
                if (rsp_last) done = 1'b1;
            end
        end
        tick;
        checks++; if (beats.size() != 4 || addrs.size() != 4) begin errors++; $display("FAIL ptr_burst_count got beats=%0d reads=%0d want 4 4", beats.size(), addrs.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < beats.size() && i < addrs.size()) begin
                checks++; if (beats[i] !== expBeat[i] || addrs[i] !== expAddr[i] || lasts[i] !== (i == 3)) begin errors++; $display("FAIL ptr_burst_beat%0d got data=%h addr=%h last=%b want %h %h %b", i, beats[i], addrs[i], lasts[i], expBeat[i], expAddr[i], i == 3); end
            end
        end
        checks++; if (ptr !== 8'h02 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ptr_burst_end got ptr=%h valid=%b ready=%b want 02 0 1", ptr, rsp_valid, req_ready); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_stall;
        logic [7:0] beats [$];
        logic [7:0] expBeat [4];
        logic [7:0] held = 8'h00;
        int         stall = 0;
        int         reads = 0;
        bit         done = 1'b0;
        expBeat = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        rsp_ready = 1'b1;
        applyStimulus(2'd2, 8'h40, 8'h00, 2'd0, 4'd3, 1'b0);
        for (int c = 0; c < 60 && !done; c++) begin
            tick;
            if (memRead) reads++;
            if (rsp_valid) begin
                if (beats.size() == 1 && stall < 5) begin
                    rsp_ready = 1'b0;
                    if (stall == 0) held = rsp_data;
                    else begin
                        checks++; if (rsp_data !== held) begin errors++; $display("FAIL stall_data cycle%0d got %h want %h", stall, rsp_data, held); end
                    end
                    checks++; if (memRead !== 1'b0) begin errors++; $display("FAIL stall_memread cycle%0d got %b want 0", stall, memRead); end
                    stall++;
                end else begin
                    rsp_ready = 1'b1;
                    beats.push_back(rsp_data);
                    if (rsp_last) done = 1'b1;
                end
            end
        end
        tick;
        checks++; if (stall != 5) begin errors++; $display("FAIL stall_cycles got %0d want 5", stall); end
        checks++; if (beats.size() != 4 || reads != 4) begin errors++; $display("FAIL stall_count got beats=%0d reads=%0d want 4 4", beats.size(), reads); end
        for (int i = 0; i < 4; i++) begin
            if (i < beats.size()) begin
                checks++; if (beats[i] !== expBeat[i]) begin errors++; $display("FAIL stall_beat%0d got %h want %h", i, beats[i], expBeat[i]); end
            end
        end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_end got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int nb = 0;
        int activity = 0;
        int spurious = 0;
        bit hit = 1'b0;
        applyStimulus(2'd3, 8'h40, 8'h00, 2'd0, 4'd0, 1'b0);
        rsp_ready = 1'b1;
        applyStimulus(2'd2, 8'h00, 8'h00, 2'd0, 4'd3, 1'b1);
        for (int c = 0; c < 20 && !hit; c++) begin
            tick;
            if (rsp_valid) begin
                if (nb == 0) nb++;
                else hit = 1'b1;
            end
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_mid_beat2 got no second beat within bound"); end
        rsp_ready = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || ptr !== 8'h00 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_state got valid=%b ptr=%h ready=%b want 0 00 1", rsp_valid, ptr, req_ready); end
        checks++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin errors++; $display("FAIL reset_mid_pins got rd=%b wr=%b want 0 0", memRead, memWrite); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (memRead || memWrite) activity++;
            if (rsp_valid) spurious++;
        end
        checks++; if (activity != 0 || spurious != 0) begin errors++; $display("FAIL reset_mid_after got strobes=%0d beats=%0d want 0 0", activity, spurious); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] beats [$];
        logic       lasts [$];
        logic [7:0] expBeat [3];
        logic       expLast [3];
        int         accepts = 0;
        int         accBeats = -1;
        bit         accPending = 1'b0;
        expBeat = '{8'hB0, 8'hB1, 8'hA7};
        expLast = '{1'b0, 1'b1, 1'b1};
        rsp_ready = 1'b1;
        applyStimulus(2'd2, 8'h40, 8'h00, 2'd0, 4'd1, 1'b0);
        req_op = 2'd0; req_addr = 8'h20; req_sel = 2'd0; req_len = 4'd0; req_use_ptr = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 40 && beats.size() < 3; c++) begin
            tick;
            if (accPending) begin
                req_valid = 1'b0;
                accPending = 1'b0;
            end
            if (rsp_valid) begin
                beats.push_back(rsp_data);
                lasts.push_back(rsp_last);
            end
            if (req_valid && req_ready) begin
                accepts++;
                accBeats = beats.size();
                accPending = 1'b1;
            end
        end
        req_valid = 1'b0;
        tick;
        checks++; if (accepts != 1 || accBeats != 2) begin errors++; $display("FAIL b2b_accept got accepts=%0d after_beats=%0d want 1 2", accepts, accBeats); end
        checks++; if (beats.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", beats.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < beats.size()) begin
                checks++; if (beats[i] !== expBeat[i] || lasts[i] !== expLast[i]) begin errors++; $display("FAIL b2b_beat%0d got data=%h last=%b want %h %b", i, beats[i], lasts[i], expBeat[i], expLast[i]); end
            end
        end
        rsp_ready = 1'b0;
        tick;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_sel;
        test_ptr_burst;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        checks++; if (overlapSeen) begin errors++; $display("FAIL rd_wr_overlap got memRead and memWrite high together want never"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencer between the string-search core's execute stage and the 256-byte data memory. It accepts load, store, burst-load and set-pointer requests over a valid/ready handshake and drives the memory's address/data/select/strobe pins. It captures read data into a held response register with backpressure. An internal 8-bit auto-increment pointer lets the core scan strings without recomputing addresses.

## Interface
- No parameters. Address 8 bits, data 8 bits, memory depth 256, all fixed.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_op  in  2  00 load, 01 store, 10 burst load, 11 set pointer.
- req_addr  in  8  byte address; new pointer value for op 11.
- req_wdata  in  8  store data.
- req_sel  in  2  read select: 0 full byte, 1 low nibble zero-extended, 2 high nibble zero-extended; 3 remapped to 0.
- req_len  in  4  burst beats minus one (1..16 beats); ignored for ops 00, 01, 11.
- req_use_ptr  in  1  use the internal pointer as the address and post-increment it per beat.
- rsp_valid  out  1  read beat available.
- rsp_ready  in  1  core consumes the beat.
- rsp_data  out  8  captured read data.
- rsp_last  out  1  final beat of the request.
- ptr  out  8  current pointer value.
- dataAddress, data  out  8 each  to memory.
- sel  out  2  to memory.
- memWrite, memRead  out  1 each  to memory.
- dataOut  in  8  from memory; valid after the falling edge of a cycle with memRead high.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1.
  - Op 11 sets ptr to req_addr, stays in IDLE and produces no response.
  - Op 01 latches address and wdata, then goes to WRITE.
  - Op 00 and op 10 latch address, sel and remaining count (0 for op 00, req_len for op 10), then go to READ.
- Address source: ptr when req_use_ptr=1, else req_addr.
- WRITE: memWrite=1 with dataAddress and data driven for exactly one cycle. The memory writes on the closing edge. Then go to IDLE. Stores are posted and produce no response.
- READ: memRead=1 with dataAddress and sel driven for exactly one cycle. On the closing edge:
  - rsp_data takes dataOut.
  - rsp_valid goes to 1; rsp_last=(remaining==0).
  - Working address increments mod 256; if use_ptr, ptr increments mod 256 (0xFF wraps to 0x00).
  - Go to RESP.
- RESP: rsp_valid, rsp_data and rsp_last are held stable. memRead=0 and memWrite=0.
  - On rsp_valid&rsp_ready: if remaining==0, clear rsp_valid and rsp_last and go to IDLE; else decrement remaining and go to READ.
- Memory pins outside the active state: memRead=0, memWrite=0, dataAddress=0, data=0, sel=0.
- memRead and memWrite are never high together.

## Timing
- Reset values: state IDLE, ptr=0x00, rsp_valid=0, rsp_data=0x00, rsp_last=0, remaining=0, all memory outputs 0. req_ready=1 from the first cycle after reset.
- Accept on edge E → READ cycle → rsp_valid high after edge E+2.
- Store on edge E → memory updated at edge E+2. The next request is accepted no earlier than edge E+2.
- Burst throughput with rsp_ready held high: one beat per 2 cycles.
- The beat is consumed in RESP when rsp_ready is sampled high. A load issued immediately after a store to the same address returns the new data.
- Reset mid-operation aborts the request. No further memRead or memWrite is asserted after the edge that samples reset, and the partial burst is discarded. A store completes only if its WRITE cycle's closing edge precedes reset.
- req_valid while req_ready=0 is ignored; the core holds the request.

## Test plan
- Store 0x5A to 0x10, then load 0x10 sel 0 → one beat, rsp_data=0x5A, rsp_last=1, rsp_valid rises 2 edges after accept.
- Memory holds 0xA7 at 0x20; loads with sel 1, 2, 3 → 0x07, 0x0A, 0xA7.
- Set ptr 0xFE; burst len=3 with use_ptr, memory FE..01 = 11,22,33,44 → beats 11,22,33,44 from addresses FE,FF,00,01; rsp_last only on 44; ptr=0x02 at the end.
- Burst of 4 with rsp_ready low for 5 cycles on beat 2 → rsp_data stable, memRead=0 throughout the stall, exactly 4 beats with no duplicates or drops.
- Assert reset in RESP of beat 2 of 4 → next cycle rsp_valid=0, ptr=0, req_ready=1, memRead=0, memWrite=0; no further beats.
- Hold req_valid during a burst → no acceptance until IDLE; the held request is accepted exactly once.
